apb_gpio_slave_bridge: RTL
==========================

Name: apb_gpio_slave_bridge

Overview:
Parametrised APB3/APB4 slave front-end for the GPIO core, the next generation of the GPIO APB slave interface. It adds wait-state support through a backend req/ack handshake, byte strobes, and a bounded ack timeout. PSLVERR is raised on decode, alignment and timeout errors. All APB outputs and the interrupt output are registered. It sits between the APB fabric and the GPIO register core.

Parameters:
ADDR_WIDTH, 8, APB address width in bits (byte addresses).
DATA_WIDTH, 32, data width; a multiple of 8.
NUM_REGS, 16, number of mapped word registers; must satisfy NUM_REGS*(DATA_WIDTH/8) <= 2**ADDR_WIDTH.
TIMEOUT, 15, REQ cycles without gpio_ack before an error response; must be >= 1.

Ports:
pclk  in  1  clock; all logic on the rising edge.
preset  in  1  asynchronous, active-high reset.
psel  in  1  APB select.
penable  in  1  APB enable / access phase.
pwrite  in  1  1 = write, 0 = read.
paddr  in  ADDR_WIDTH  byte address.
pwdata  in  DATA_WIDTH  write data.
pstrb  in  DATA_WIDTH/8  write byte strobes.
pready  out  1  transfer complete, registered.
prdata  out  DATA_WIDTH  read data, registered.
pslverr  out  1  error response, valid only with pready.
gpio_req  out  1  backend request, held until ack or abort.
gpio_we  out  1  backend write enable, qualified by gpio_req.
gpio_addr  out  $clog2(NUM_REGS)  word index.
gpio_wdat  out  DATA_WIDTH  backend write data.
gpio_be  out  DATA_WIDTH/8  byte enables: pstrb on writes, all ones on reads.
gpio_ack  in  1  backend completion; sampled only in REQ.
gpio_rdat  in  DATA_WIDTH  backend read data, valid with gpio_ack.
gpio_inta_o  in  1  GPIO core interrupt.
irq  out  1  registered copy of gpio_inta_o.

Behaviour:
- Reset (async, preset=1): state=IDLE. pready, pslverr, gpio_req, gpio_we, irq = 0. prdata, gpio_addr, gpio_wdat = 0. gpio_be = 0. Counter = 0.
- FSM states: IDLE, REQ, DONE.
- IDLE: when psel & ~penable (setup phase), capture pwrite, word index = paddr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)], pwdata and pstrb.
  - If the index is >= NUM_REGS or the low byte-offset bits are nonzero: go to DONE with err=1 and issue no backend request.
  - Otherwise: go to REQ with gpio_req=1 and counter=0.
- REQ: gpio_req, gpio_we, gpio_addr, gpio_wdat and gpio_be are stable.
  - gpio_ack=1: drop gpio_req. On a read, latch gpio_rdat into prdata. Go to DONE with err=0.
  - No ack and counter==TIMEOUT-1: drop gpio_req and go to DONE with err=1, prdata=0.
  - Otherwise counter increments.
  - psel=0 (master abort): drop gpio_req and return to IDLE with no response. The backend must tolerate a withdrawn request.
- DONE: pready=1 for exactly one cycle; pslverr=err. prdata holds read data only for a successful read and is 0 otherwise. Next state is always IDLE.
- Leaving DONE, prdata, pslverr and pready return to 0.
- Latency:
  - Ack in the first REQ cycle: setup at T, pready at T+2 (one wait state).
  - Decode or alignment error: pready at T+1 (zero wait states).
  - Timeout: pready at T+1+TIMEOUT.
- Back-to-back transfers: a master setup phase in the cycle after DONE is accepted directly from IDLE, with no idle-cycle penalty beyond the APB protocol itself.
- gpio_ack outside REQ is ignored. prdata is never driven from gpio_rdat combinationally.
- A write with pstrb all zero is forwarded with gpio_be=0. The backend treats it as a no-op that is still acked.
- irq <= gpio_inta_o every cycle, giving 1-cycle latency.
- Reset asserted mid-transfer: immediate return to reset values. Any in-flight request is dropped and no pready is issued.

Decomposition:
- Shared package apb_gpio_pkg: the state enum (IDLE/REQ/DONE), the byte-offset-width helper function, and the ERR/OK response constants.
- One natural sub-module: apb_gpio_addr_decode. It is combinational and produces the word index, decode error and alignment error from paddr. The FSM, timeout counter and output registers stay in the top.

Test Plan:
- Write, default parameters: setup paddr=0x08, pwdata=0xDEADBEEF, pstrb=0xF; backend acks in the 1st REQ cycle.
  -> gpio_addr=2, gpio_be=0xF, gpio_wdat=0xDEADBEEF; pready at T+2 with pslverr=0.
- Read with a 3-cycle ack delay: paddr=0x3C, gpio_rdat=0x12345678.
  -> gpio_req held 3 cycles; prdata=0x12345678 with pready at T+4; prdata=0 the following cycle.
- Decode errors: paddr=0x40 (index 16), then paddr=0x05 (misaligned).
  -> gpio_req stays 0; pready at T+1 with pslverr=1 and prdata=0 for both.
- Timeout: read of 0x00 with gpio_ack tied 0.
  -> gpio_req high for exactly 15 cycles; pready with pslverr=1 at T+16.
- Back-to-back write then read, plus a master abort (psel=0 in REQ).
  -> two correct completions with no extra idle cycle; the aborted transfer produces no pready and the FSM is in IDLE next cycle.
- preset pulsed during REQ, and gpio_inta_o toggling.
  -> all outputs 0 immediately and FSM in IDLE; irq follows gpio_inta_o with 1-cycle delay once preset is released.

Source files
------------

// File: rtl/apb_gpio_pkg.sv
// Shared types and constants for the APB-to-GPIO slave bridge.
package apb_gpio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    // Number of byte-offset bits below the word index in a byte address.
    function automatic int byte_off_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_gpio_addr_decode.sv
// Combinational byte-address decode: word index, range error, alignment error.
module apb_gpio_addr_decode
    import apb_gpio_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = 4
) (
    input  logic [ADDR_WIDTH-1:0] paddr,
    output logic [IDX_W-1:0]      idx,
    output logic                  dec_err,
    output logic                  align_err
);

    localparam int OFF = byte_off_bits(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF) - 1);

    logic [ADDR_WIDTH-1:0] word;

    assign word = paddr >> OFF;
    assign idx  = word[IDX_W-1:0];

    // One extra bit so NUM_REGS == 2**ADDR_WIDTH does not wrap to zero.
    assign dec_err   = {1'b0, word} >= (ADDR_WIDTH + 1)'(NUM_REGS);
    assign align_err = |(paddr & OFF_MASK);

endmodule

// File: rtl/apb_gpio_slave_bridge.sv
// APB3/APB4 slave front-end for the GPIO core with backend req/ack and ack timeout.
//   state   | meaning
//   IDLE    | waiting for an APB setup phase
//   REQ     | backend request outstanding, counting toward timeout
//   DONE    | pready high for one cycle with pslverr/prdata
module apb_gpio_slave_bridge
    import apb_gpio_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_WIDTH-1:0]        paddr,
    input  logic [DATA_WIDTH-1:0]        pwdata,
    input  logic [DATA_WIDTH/8-1:0]      pstrb,
    output logic                         pready,
    output logic [DATA_WIDTH-1:0]        prdata,
    output logic                         pslverr,
    output logic                         gpio_req,
    output logic                         gpio_we,
    output logic [$clog2(NUM_REGS)-1:0]  gpio_addr,
    output logic [DATA_WIDTH-1:0]        gpio_wdat,
    output logic [DATA_WIDTH/8-1:0]      gpio_be,
    input  logic                         gpio_ack,
    input  logic [DATA_WIDTH-1:0]        gpio_rdat,
    input  logic                         gpio_inta_o,
    output logic                         irq
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] dec_idx;
    logic             dec_err;
    logic             align_err;

    apb_gpio_addr_decode #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W)
    ) u_decode (
        .paddr    (paddr),
        .idx      (dec_idx),
        .dec_err  (dec_err),
        .align_err(align_err)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
            gpio_req  <= 1'b0;
            gpio_we   <= 1'b0;
            gpio_addr <= '0;
            gpio_wdat <= '0;
            gpio_be   <= '0;
            irq       <= 1'b0;
        end else begin
            irq <= gpio_inta_o;
            case (state)
                ST_IDLE: begin
                    if (psel && !penable) begin
                        if (dec_err || align_err) begin
                            state   <= ST_DONE;
                            pready  <= 1'b1;
                            pslverr <= RESP_ERR;
                            prdata  <= '0;
                        end else begin
                            state     <= ST_REQ;
                            cnt       <= '0;
                            gpio_req  <= 1'b1;
                            gpio_we   <= pwrite;
                            gpio_addr <= dec_idx;
                            gpio_wdat <= pwdata;
                            gpio_be   <= pwrite ? pstrb : '1;
                        end
                    end
                end
                ST_REQ: begin
                    // A withdrawn select wins: there is no master left to answer.
                    if (!psel) begin
                        state    <= ST_IDLE;
                        gpio_req <= 1'b0;
                        gpio_we  <= 1'b0;
                    end else if (gpio_ack) begin
                        state    <= ST_DONE;
                        gpio_req <= 1'b0;
                        gpio_we  <= 1'b0;
                        pready   <= 1'b1;
                        pslverr  <= RESP_OK;
                        prdata   <= gpio_we ? '0 : gpio_rdat;
                    end else if (cnt == CNT_LAST) begin
                        state    <= ST_DONE;
                        gpio_req <= 1'b0;
                        gpio_we  <= 1'b0;
                        pready   <= 1'b1;
                        pslverr  <= RESP_ERR;
                        prdata   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
